// File: rtl/fountain_pkg.sv
// Shared state encoding for the fountain button conditioner and its bench monitors.
package fountain_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_QUAL_ON  = 3'd1;
  localparam logic [2:0] ST_PRESSED  = 3'd2;
  localparam logic [2:0] ST_QUAL_OFF = 3'd3;
  localparam logic [2:0] ST_LOCKOUT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    QUAL_ON  = ST_QUAL_ON,
    PRESSED  = ST_PRESSED,
    QUAL_OFF = ST_QUAL_OFF,
    LOCKOUT  = ST_LOCKOUT
  } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, cleared by sync reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1;
  logic s2;

  // Capture the asynchronous pin, then re-register to let metastability settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s2;

endmodule

// File: rtl/fountain_button_conditioner.sv
// Conditions the raw fountain push-button: synchronise, debounce press and
// release, and trip a stuck-button lockout after an over-long press.
module fountain_button_conditioner
  import fountain_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MAX_PRESS_CYCLES = 1000,
  parameter int CNT_W            = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic button_clean,
  output logic press_event,
  output logic press_stuck
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(MAX_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam bit               GUARD_EN   = (MAX_PRESS_CYCLES != 0);

  // Counters hold at full scale rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  logic             btn_s;
  btn_state_t       state, state_nx;
  logic [CNT_W-1:0] db_cnt, db_cnt_nx;
  logic [CNT_W-1:0] press_cnt, press_cnt_nx;
  logic             event_nx;
  logic             guard_hit;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (button_raw),
    .dout  (btn_s)
  );

  // Register FSM state, counters and the outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      db_cnt       <= '0;
      press_cnt    <= '0;
      button_clean <= 1'b0;
      press_event  <= 1'b0;
      press_stuck  <= 1'b0;
    end else begin
      state        <= state_nx;
      db_cnt       <= db_cnt_nx;
      press_cnt    <= press_cnt_nx;
      button_clean <= (state_nx == PRESSED) || (state_nx == QUAL_OFF);
      press_event  <= event_nx;
      press_stuck  <= (state_nx == LOCKOUT);
    end
  end

  // Next-state and counter logic; the stuck guard outranks release and bounce-back.
  always_comb begin
    state_nx     = state;
    db_cnt_nx    = db_cnt;
    press_cnt_nx = press_cnt;
    event_nx     = 1'b0;
    guard_hit    = GUARD_EN && (press_cnt == PRESS_LAST);

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx  = QUAL_ON;
          db_cnt_nx = '0;
        end
      end

      QUAL_ON: begin
        if (!btn_s) begin
          state_nx = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nx     = PRESSED;
          press_cnt_nx = '0;
          event_nx     = 1'b1;
        end else begin
          db_cnt_nx = sat_inc(db_cnt);
        end
      end

      PRESSED: begin
        if (guard_hit) begin
          state_nx  = LOCKOUT;
          db_cnt_nx = '0;
        end else begin
          press_cnt_nx = sat_inc(press_cnt);
          if (!btn_s) begin
            state_nx  = QUAL_OFF;
            db_cnt_nx = '0;
          end
        end
      end

      QUAL_OFF: begin
        if (guard_hit) begin
          state_nx  = LOCKOUT;
          db_cnt_nx = '0;
        end else begin
          press_cnt_nx = sat_inc(press_cnt);
          if (btn_s) begin
            state_nx = PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state_nx = IDLE;
          end else begin
            db_cnt_nx = sat_inc(db_cnt);
          end
        end
      end

      LOCKOUT: begin
        if (btn_s) begin
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx = IDLE;
        end else begin
          db_cnt_nx = sat_inc(db_cnt);
        end
      end

      default: begin
        state_nx  = IDLE;
        db_cnt_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fountain_button_conditioner.sv
// Directed bench for the fountain button conditioner (D=4, MAX=20).
module tb_fountain_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_raw = 1'b0;
  logic button_clean;
  logic press_event;
  logic press_stuck;

  int n_chk = 0;
  int n_fail = 0;

  fountain_button_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .MAX_PRESS_CYCLES (20),
    .CNT_W            (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .button_clean (button_clean),
    .press_event  (press_event),
    .press_stuck  (press_stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic raw;
    logic clean;
    logic ev;
    logic stuck;
  } vec_t;

  vec_t tbl[40];

  // Drive inputs, let them be sampled by one rising edge, then settle.
  task automatic cyc(input logic r, input logic b);
    reset      = r;
    button_raw = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int ev_count;
    logic raw_v;

    // Reset rows, then a 15-cycle clean press (edge n = row index - 4) and a 3-cycle glitch.
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, logic'(i % 2), 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 36; n++) begin
      tbl[n+4].rst   = 1'b0;
      tbl[n+4].raw   = (n < 15) || (n >= 25 && n < 28);
      tbl[n+4].clean = (n >= 6) && (n <= 20);
      tbl[n+4].ev    = (n == 6);
      tbl[n+4].stuck = 1'b0;
    end

    for (int i = 0; i < 40; i++) begin
      cyc(tbl[i].rst, tbl[i].raw);
      chk($sformatf("table[%0d] clean", i), button_clean, tbl[i].clean);
      chk($sformatf("table[%0d] event", i), press_event, tbl[i].ev);
      chk($sformatf("table[%0d] stuck", i), press_stuck, tbl[i].stuck);
    end
    repeat (4) cyc(1'b0, 1'b0);

    // Release bounce: low 2, high 1, then low held; clean falls 6 edges after final low.
    for (int n = 0; n <= 24; n++) begin
      raw_v = (n < 10) || (n == 12);
      cyc(1'b0, raw_v);
      if (n >= 6) chk($sformatf("bounce clean edge %0d", n), button_clean, logic'(n <= 18));
      if (n == 18) chk("bounce stuck", press_stuck, 1'b0);
    end
    repeat (4) cyc(1'b0, 1'b0);

    // Stuck button: lockout 20 cycles after rise, recovery, then a fresh press.
    ev_count = 0;
    for (int n = 0; n <= 70; n++) begin
      raw_v = (n < 40) || (n >= 50 && n < 60);
      cyc(1'b0, raw_v);
      if (press_event) ev_count++;
      case (n)
        25: begin
          chk("stuck clean before guard", button_clean, 1'b1);
          chk("stuck flag before guard", press_stuck, 1'b0);
        end
        26: begin
          chk("stuck clean at guard", button_clean, 1'b0);
          chk("stuck flag at guard", press_stuck, 1'b1);
        end
        39: chk("stuck flag while held", press_stuck, 1'b1);
        43: chk("stuck flag during release qual", press_stuck, 1'b1);
        46: begin
          chk("stuck flag cleared", press_stuck, 1'b0);
          chk("stuck clean after recovery", button_clean, 1'b0);
        end
        55: chk("requalify clean not yet", button_clean, 1'b0);
        56: begin
          chk("requalify clean", button_clean, 1'b1);
          chk("requalify event", press_event, 1'b1);
        end
        65: chk("requalify release not yet", button_clean, 1'b1);
        66: chk("requalify released", button_clean, 1'b0);
        default: ;
      endcase
    end
    chk_int("stuck scenario event count", ev_count, 2);
    repeat (4) cyc(1'b0, 1'b0);

    // Release qualification finishing on the guard cycle must land in lockout.
    for (int n = 0; n <= 35; n++) begin
      cyc(1'b0, logic'(n < 20));
      case (n)
        21: chk("simul clean held", button_clean, 1'b1);
        25: chk("simul stuck before", press_stuck, 1'b0);
        26: begin
          chk("simul clean at collision", button_clean, 1'b0);
          chk("simul stuck at collision", press_stuck, 1'b1);
        end
        35: chk("simul stuck recovered", press_stuck, 1'b0);
        default: ;
      endcase
    end
    repeat (4) cyc(1'b0, 1'b0);

    // Reset pulse mid-press with the button still held forces re-qualification.
    ev_count = 0;
    for (int n = 0; n <= 25; n++) begin
      cyc(logic'(n == 11), 1'b1);
      if (press_event) ev_count++;
      case (n)
        10: chk("rstmid clean before", button_clean, 1'b1);
        11: begin
          chk("rstmid clean after reset", button_clean, 1'b0);
          chk("rstmid event after reset", press_event, 1'b0);
          chk("rstmid stuck after reset", press_stuck, 1'b0);
        end
        17: chk("rstmid clean not yet", button_clean, 1'b0);
        18: begin
          chk("rstmid clean re-rise", button_clean, 1'b1);
          chk("rstmid event re-rise", press_event, 1'b1);
        end
        19: chk("rstmid event single", press_event, 1'b0);
        default: ;
      endcase
    end
    chk_int("rstmid event count", ev_count, 2);
    repeat (10) cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
